// File: rtl/psa_byte_streamer.sv
// rtl/psa_byte_streamer.sv - BRAM window reader presenting address-tagged bytes as a valid/ready stream
module psa_byte_streamer #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              CLK100MHZ,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic              bram_ena,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [DATA_W-1:0] bram_douta,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_last
);

    localparam int CNT_W = ADDR_W + 1;
    localparam int DEPTH = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   issued_q, issued_d;
    logic [CNT_W-1:0]   delivered_q, delivered_d;
    logic               bram_ena_q, bram_ena_d;
    logic [ADDR_W-1:0]  bram_addr_q, bram_addr_d;

    // Return pipe: one marker bit and address tag per cycle of read latency.
    logic [RD_LAT-1:0]  pipe_vld_q, pipe_vld_d;
    logic [ADDR_W-1:0]  pipe_addr_q [RD_LAT];
    logic [ADDR_W-1:0]  pipe_addr_d [RD_LAT];

    logic [DATA_W-1:0]  fifo_data_q [DEPTH];
    logic [DATA_W-1:0]  fifo_data_d [DEPTH];
    logic [ADDR_W-1:0]  fifo_addr_q [DEPTH];
    logic [ADDR_W-1:0]  fifo_addr_d [DEPTH];
    logic [1:0]         wr_ptr_q, wr_ptr_d;
    logic [1:0]         rd_ptr_q, rd_ptr_d;
    logic [2:0]         count_q, count_d;

    logic               push;
    logic               pop;
    logic               issue;
    logic [3:0]         inflight;
    logic [3:0]         occupancy;

    // Next-state, read issue, return pipe and skid FIFO bookkeeping.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        len_d       = len_q;
        issued_d    = issued_q;
        bram_ena_d  = 1'b0;
        bram_addr_d = bram_addr_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fifo_data_d = fifo_data_q;
        fifo_addr_d = fifo_addr_q;
        issue       = 1'b0;

        push = pipe_vld_q[RD_LAT-1];
        pop  = (count_q != 3'd0) && m_ready;

        // Reads already committed: the one on the BRAM port plus those in the pipe.
        inflight = {3'b000, bram_ena_q};
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + {3'b000, pipe_vld_q[i]};
        end
        // A beat leaving this cycle frees its slot, which keeps 1 beat/cycle at RD_LAT=2.
        occupancy = {1'b0, count_q} + inflight - {3'b000, pop};

        delivered_d = delivered_q + {{ADDR_W{1'b0}}, pop};

        case (state_q)
            S_IDLE: begin
                issued_d    = '0;
                delivered_d = '0;
                if (start) begin
                    base_d = base_addr;
                    len_d  = length;
                    // A zero-length window spends one cycle in RUN, where the completion compare fires at once.
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if ((issued_q < len_q) && (occupancy < 4'(DEPTH))) begin
                    issue = 1'b1;
                end
                if (delivered_d == len_q) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (issue) begin
            bram_ena_d  = 1'b1;
            bram_addr_d = base_q + issued_q[ADDR_W-1:0];
            issued_d    = issued_q + {{ADDR_W{1'b0}}, 1'b1};
        end

        pipe_vld_d     = pipe_vld_q;
        pipe_addr_d    = pipe_addr_q;
        pipe_vld_d[0]  = bram_ena_q;
        pipe_addr_d[0] = bram_addr_q;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_vld_d[i]  = pipe_vld_q[i-1];
            pipe_addr_d[i] = pipe_addr_q[i-1];
        end

        if (push) begin
            fifo_data_d[wr_ptr_q] = bram_douta;
            fifo_addr_d[wr_ptr_q] = pipe_addr_q[RD_LAT-1];
            wr_ptr_d              = wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        count_d = count_q + {2'b00, push} - {2'b00, pop};
    end

    // State register; reset also drops any reads still travelling through the pipe.
    always_ff @(posedge CLK100MHZ) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            len_q       <= '0;
            issued_q    <= '0;
            delivered_q <= '0;
            bram_ena_q  <= 1'b0;
            bram_addr_q <= '0;
            pipe_vld_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_addr_q[i] <= '0;
            end
            for (int i = 0; i < DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_addr_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            len_q       <= len_d;
            issued_q    <= issued_d;
            delivered_q <= delivered_d;
            bram_ena_q  <= bram_ena_d;
            bram_addr_q <= bram_addr_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_addr_q <= pipe_addr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            fifo_data_q <= fifo_data_d;
            fifo_addr_q <= fifo_addr_d;
        end
    end

    // Outputs; the stream fields are forced to zero whenever no beat is offered.
    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_FIN);
        bram_ena  = bram_ena_q;
        bram_addr = bram_addr_q;
        m_valid   = (count_q != 3'd0);
        m_data    = m_valid ? fifo_data_q[rd_ptr_q] : '0;
        m_addr    = m_valid ? fifo_addr_q[rd_ptr_q] : '0;
        m_last    = m_valid && (delivered_q == (len_q - {{ADDR_W{1'b0}}, 1'b1}));
    end

endmodule

// File: tb/tb_psa_byte_streamer.sv
// tb/tb_psa_byte_streamer.sv - scoreboard bench for psa_byte_streamer at RD_LAT 1 and 2
module tb_psa_byte_streamer;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
        logic       l;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start1 = 1'b0, start2 = 1'b0;
    logic [7:0] base1 = '0, base2 = '0;
    logic [8:0] len1 = '0, len2 = '0;
    logic       ready1 = 1'b1, ready2 = 1'b1;
    logic       busy1, done1, ena1, valid1, last1;
    logic       busy2, done2, ena2, valid2, last2;
    logic [7:0] addr1, data1, maddr1, douta1;
    logic [7:0] addr2, data2, maddr2, douta2, r2;

    int n_cmp = 0;
    int n_err = 0;

    beat_t q1[$];
    beat_t q2[$];

    always #5 clk = ~clk;

    psa_byte_streamer #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1)) dut1 (
        .CLK100MHZ(clk), .reset(rst_n), .start(start1), .base_addr(base1), .length(len1),
        .busy(busy1), .done(done1), .bram_ena(ena1), .bram_addr(addr1), .bram_douta(douta1),
        .m_valid(valid1), .m_ready(ready1), .m_data(data1), .m_addr(maddr1), .m_last(last1)
    );

    psa_byte_streamer #(.ADDR_W(8), .DATA_W(8), .RD_LAT(2)) dut2 (
        .CLK100MHZ(clk), .reset(rst_n), .start(start2), .base_addr(base2), .length(len2),
        .busy(busy2), .done(done2), .bram_ena(ena2), .bram_addr(addr2), .bram_douta(douta2),
        .m_valid(valid2), .m_ready(ready2), .m_data(data2), .m_addr(maddr2), .m_last(last2)
    );

    // BRAM models holding mem[a] = a ^ 8'h5A
    initial begin douta1 = '0; r2 = '0; douta2 = '0; end
    always @(posedge clk) begin
        if (ena1) douta1 <= addr1 ^ 8'h5A;
        if (ena2) r2 <= addr2 ^ 8'h5A;
        douta2 <= r2;
    end

    // Monitor dut1: scoreboard pops, stall hold, outstanding-read bound
    int iss1 = 0, hs1 = 0;
    logic stall1 = 1'b0;
    logic [16:0] held1 = '0;
    always @(negedge clk) begin
        beat_t e;
        if (!rst_n) begin
            iss1 = 0; hs1 = 0; stall1 = 1'b0;
        end else begin
            if (stall1) begin
                n_cmp++;
                if (!valid1 || {maddr1, data1, last1} !== held1) begin
                    n_err++;
                    $display("FAIL stall_hold1: got v=%0b %h, required v=1 %h", valid1, {maddr1, data1, last1}, held1);
                end
            end
            stall1 = valid1 && !ready1;
            held1  = {maddr1, data1, last1};
            if (ena1) begin
                iss1++;
                n_cmp++;
                if (iss1 - hs1 > 4) begin
                    n_err++;
                    $display("FAIL outstanding1: got %0d, required <= 4", iss1 - hs1);
                end
            end
            if (valid1 && ready1) begin
                hs1++;
                n_cmp++;
                if (q1.size() == 0) begin
                    n_err++;
                    $display("FAIL extra_beat1: got addr=%0d data=%h, required no beat", maddr1, data1);
                end else begin
                    e = q1.pop_front();
                    if ({maddr1, data1, last1} !== e) begin
                        n_err++;
                        $display("FAIL beat1: got a=%0d d=%h l=%0b, required a=%0d d=%h l=%0b",
                                 maddr1, data1, last1, e.a, e.d, e.l);
                    end
                end
            end
        end
    end

    // Monitor dut2: same checks for the RD_LAT=2 instance
    int iss2 = 0, hs2 = 0;
    logic stall2 = 1'b0;
    logic [16:0] held2 = '0;
    always @(negedge clk) begin
        beat_t e;
        if (!rst_n) begin
            iss2 = 0; hs2 = 0; stall2 = 1'b0;
        end else begin
            if (stall2) begin
                n_cmp++;
                if (!valid2 || {maddr2, data2, last2} !== held2) begin
                    n_err++;
                    $display("FAIL stall_hold2: got v=%0b %h, required v=1 %h", valid2, {maddr2, data2, last2}, held2);
                end
            end
            stall2 = valid2 && !ready2;
            held2  = {maddr2, data2, last2};
            if (ena2) begin
                iss2++;
                n_cmp++;
                if (iss2 - hs2 > 4) begin
                    n_err++;
                    $display("FAIL outstanding2: got %0d, required <= 4", iss2 - hs2);
                end
            end
            if (valid2 && ready2) begin
                hs2++;
                n_cmp++;
                if (q2.size() == 0) begin
                    n_err++;
                    $display("FAIL extra_beat2: got addr=%0d data=%h, required no beat", maddr2, data2);
                end else begin
                    e = q2.pop_front();
                    if ({maddr2, data2, last2} !== e) begin
                        n_err++;
                        $display("FAIL beat2: got a=%0d d=%h l=%0b, required a=%0d d=%h l=%0b",
                                 maddr2, data2, last2, e.a, e.d, e.l);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy1, done1, ena1, addr1, valid1, data1, maddr1, last1} !== 28'd0) begin
            n_err++;
            $display("FAIL reset_outputs1: got %h, required 0", {busy1, done1, ena1, addr1, valid1, data1, maddr1, last1});
        end
        n_cmp++;
        if ({busy2, done2, ena2, addr2, valid2, data2, maddr2, last2} !== 28'd0) begin
            n_err++;
            $display("FAIL reset_outputs2: got %h, required 0", {busy2, done2, ena2, addr2, valid2, data2, maddr2, last2});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int first_v = -1, last_c = -1, done_c = -1, n_done = 0;
        logic busy_c0 = 1'b0, busy_c9 = 1'b1;
        q1.push_back({8'd10, 8'h50, 1'b0});
        q1.push_back({8'd11, 8'h51, 1'b0});
        q1.push_back({8'd12, 8'h56, 1'b0});
        q1.push_back({8'd13, 8'h57, 1'b0});
        q1.push_back({8'd14, 8'h54, 1'b1});
        ready1 = 1'b1; base1 = 8'd10; len1 = 9'd5; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (valid1 && first_v < 0) first_v = c;
            if (valid1 && last1) last_c = c;
            if (done1) begin n_done++; if (done_c < 0) done_c = c; end
            if (c == 0) busy_c0 = busy1;
            if (c == 9) busy_c9 = busy1;
        end
        n_cmp++;
        if (first_v != 3) begin n_err++; $display("FAIL basic_first_valid: got cycle %0d, required 3", first_v); end
        n_cmp++;
        if (last_c != 7) begin n_err++; $display("FAIL basic_last: got cycle %0d, required 7", last_c); end
        n_cmp++;
        if (done_c != 8 || n_done != 1) begin n_err++; $display("FAIL basic_done: got cycle %0d x%0d, required cycle 8 x1", done_c, n_done); end
        n_cmp++;
        if (busy_c0 !== 1'b1 || busy_c9 !== 1'b0) begin n_err++; $display("FAIL basic_busy: got %0b/%0b, required 1/0", busy_c0, busy_c9); end
        n_cmp++;
        if (q1.size() != 0) begin n_err++; $display("FAIL basic_missing: got %0d beats left, required 0", q1.size()); end
    endtask

    task automatic test_wrap();
        int n_beats = 0, n_done = 0;
        q1.push_back({8'd254, 8'hA4, 1'b0});
        q1.push_back({8'd255, 8'hA5, 1'b0});
        q1.push_back({8'd0,   8'h5A, 1'b0});
        q1.push_back({8'd1,   8'h5B, 1'b1});
        base1 = 8'd254; len1 = 9'd4; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (valid1 && ready1) n_beats++;
            if (done1) n_done++;
        end
        n_cmp++;
        if (n_beats != 4 || n_done != 1) begin n_err++; $display("FAIL wrap_count: got %0d beats %0d done, required 4 beats 1 done", n_beats, n_done); end
        n_cmp++;
        if (q1.size() != 0) begin n_err++; $display("FAIL wrap_missing: got %0d beats left, required 0", q1.size()); end
    endtask

    task automatic test_zero();
        int n_ena = 0, n_v = 0, n_busy = 0, n_done = 0, done_c = -1;
        base1 = 8'd5; len1 = 9'd0; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (ena1) n_ena++;
            if (valid1) n_v++;
            if (busy1) n_busy++;
            if (done1) begin n_done++; done_c = c; end
        end
        n_cmp++;
        if (n_ena != 0 || n_v != 0) begin n_err++; $display("FAIL zero_activity: got ena=%0d valid=%0d, required 0/0", n_ena, n_v); end
        n_cmp++;
        if (n_busy != 2) begin n_err++; $display("FAIL zero_busy: got %0d cycles, required 2", n_busy); end
        n_cmp++;
        if (n_done != 1 || done_c != 1) begin n_err++; $display("FAIL zero_done: got x%0d at %0d, required x1 at 1", n_done, done_c); end
    endtask

    task automatic test_rdlat2();
        int stall_left = 0, n_beats = 0;
        logic seen_done = 1'b0;
        for (int a = 0; a < 20; a++) begin
            logic [7:0] ab;
            ab = 8'(a);
            q2.push_back({ab, ab ^ 8'h5A, (a == 19)});
        end
        base2 = 8'd0; len2 = 9'd20; start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        for (int c = 0; c < 600 && !seen_done; c++) begin
            @(negedge clk);
            if (valid2 && ready2) n_beats++;
            if (done2) seen_done = 1'b1;
            @(posedge clk); #1;
            if (stall_left > 0) begin
                ready2 = 1'b0;
                stall_left--;
            end else if ($urandom_range(0, 2) == 0) begin
                ready2 = 1'b0;
                stall_left = $urandom_range(0, 6);
            end else begin
                ready2 = 1'b1;
            end
        end
        ready2 = 1'b1;
        n_cmp++;
        if (!seen_done) begin n_err++; $display("FAIL rdlat2_done: got no done in 600 cycles, required done"); end
        n_cmp++;
        if (n_beats != 20 || q2.size() != 0) begin n_err++; $display("FAIL rdlat2_count: got %0d beats %0d left, required 20/0", n_beats, q2.size()); end
    endtask

    task automatic test_abort();
        int hs = 0, n_v = 0, n_beats = 0;
        logic pulsed = 1'b0, seen_done = 1'b0;
        for (int a = 30; a < 40; a++) begin
            logic [7:0] ab;
            ab = 8'(a);
            q1.push_back({ab, ab ^ 8'h5A, (a == 39)});
        end
        ready1 = 1'b1; base1 = 8'd30; len1 = 9'd10; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        for (int c = 0; c < 40 && hs < 3; c++) begin
            @(negedge clk);
            start1 = 1'b0;
            if (valid1 && ready1) hs++;
            if (hs == 1 && !pulsed) begin
                pulsed = 1'b1;
                start1 = 1'b1; base1 = 8'd200; len1 = 9'd3;
            end
        end
        @(posedge clk); #1;
        start1 = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({busy1, done1, ena1, addr1, valid1, data1, maddr1, last1} !== 28'd0) begin
            n_err++;
            $display("FAIL abort_reset: got %h, required 0", {busy1, done1, ena1, addr1, valid1, data1, maddr1, last1});
        end
        n_cmp++;
        if (q1.size() != 7) begin n_err++; $display("FAIL abort_prefix: got %0d beats left, required 7", q1.size()); end
        q1.delete();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (valid1) n_v++;
        end
        n_cmp++;
        if (n_v != 0) begin n_err++; $display("FAIL abort_stale: got %0d valid cycles, required 0", n_v); end
        q1.push_back({8'd100, 8'h3E, 1'b0});
        q1.push_back({8'd101, 8'h3F, 1'b1});
        base1 = 8'd100; len1 = 9'd2; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        for (int c = 0; c < 20 && !seen_done; c++) begin
            @(negedge clk);
            if (valid1 && ready1) n_beats++;
            if (done1) seen_done = 1'b1;
        end
        n_cmp++;
        if (!seen_done || n_beats != 2 || q1.size() != 0) begin
            n_err++;
            $display("FAIL abort_restart: got done=%0b beats=%0d left=%0d, required 1/2/0", seen_done, n_beats, q1.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_full();
        int n_beats = 0, n_done = 0, first_v = -1, last_c = -1;
        for (int a = 0; a < 256; a++) begin
            logic [7:0] ab;
            ab = 8'(a);
            q1.push_back({ab, ab ^ 8'h5A, (a == 255)});
        end
        ready1 = 1'b1; base1 = 8'd0; len1 = 9'd256; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (valid1 && ready1) begin
                n_beats++;
                if (first_v < 0) first_v = c;
                last_c = c;
            end
            if (done1) n_done++;
        end
        n_cmp++;
        if (n_beats != 256 || q1.size() != 0) begin n_err++; $display("FAIL full_count: got %0d beats %0d left, required 256/0", n_beats, q1.size()); end
        n_cmp++;
        if (last_c - first_v != 255) begin n_err++; $display("FAIL full_rate: got span %0d, required 255", last_c - first_v); end
        n_cmp++;
        if (n_done != 1) begin n_err++; $display("FAIL full_done: got %0d pulses, required 1", n_done); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_zero();
        test_rdlat2();
        test_abort();
        test_full();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
